// File: rtl/fifo_pkg.sv
// Shared FIFO package: default entry width, packer accumulator states and a
// width helper for counter sizing.
package fifo_pkg;

  // Entry width shared between the FIFO and its read-side consumers.
  localparam int unsigned DATASIZE_DEF = 8;

  // Accumulator occupancy, derived from the lane counter.
  typedef enum logic [1:0] {
    ACC_EMPTY   = 2'd0,
    ACC_PARTIAL = 2'd1,
    ACC_FULL    = 2'd2
  } acc_state_e;

  // Ceiling log2. Never returns 0, so a width built from it is always legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'(1) << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packer bus: FIFO read side (i_empty, i_rd_data, o_rd_en) and the packed
// output stream (o_word, o_byte_en, o_valid, i_ready).
// master: the packer; slave: FIFO/downstream side.
interface fifo_rd_packer_if #(
  parameter int unsigned DATASIZE = fifo_pkg::DATASIZE_DEF,
  parameter int unsigned PACK     = 4
);

  logic                     i_empty;
  logic [DATASIZE-1:0]      i_rd_data;
  logic                     o_rd_en;
  logic [DATASIZE*PACK-1:0] o_word;
  logic [PACK-1:0]          o_byte_en;
  logic                     o_valid;
  logic                     i_ready;

  modport master (
    input  i_empty, i_rd_data, i_ready,
    output o_rd_en, o_word, o_byte_en, o_valid
  );

  modport slave (
    output i_empty, i_rd_data, i_ready,
    input  o_rd_en, o_word, o_byte_en, o_valid
  );

endinterface

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter for the packer flush timeout.
// Ports: clk, rst_n (sync, active-low), clr (zero the count), en (count
// enable), expired_c (count has reached TIMEOUT).
module fifo_rd_idle_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TOW     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TOW-1:0] idle_q;

  assign expired_c = (idle_q == TOW'(TIMEOUT));

  // Count up while enabled, holding at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (clr) begin
      idle_q <= '0;
    end else if (en && !expired_c) begin
      idle_q <= idle_q + TOW'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries while the FIFO is not empty, packs
// PACK entries little-endian into one word and presents it on a registered
// valid/ready stream. A partial word is flushed with a lane mask after
// TIMEOUT idle clocks (TIMEOUT=0 disables flushing).
// Ports: i_rd_clk, i_rd_rst_n (sync, active-low), bus (master modport):
//   i_empty/i_rd_data/o_rd_en to the FIFO, o_word/o_byte_en/o_valid/i_ready
//   to the consumer. o_rd_en is combinational; all other outputs registered.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned PACK     = 4,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CNTW     = clog2(PACK + 1),
  parameter int unsigned TOW      = clog2(TIMEOUT + 1)
) (
  input logic            i_rd_clk,
  input logic            i_rd_rst_n,
  fifo_rd_packer_if.master bus
);

  localparam int unsigned WORDW    = DATASIZE * PACK;
  localparam bit          FLUSH_EN = (TIMEOUT != 0);

  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WORDW-1:0] acc_q, acc_d;
  logic [WORDW-1:0] word_q, word_d;
  logic [PACK-1:0]  be_q, be_d;
  logic             valid_q, valid_d;

  acc_state_e       acc_state;
  logic [WORDW-1:0] acc_wr;
  logic             rd_en_c;
  logic             out_free;
  logic             load_full;
  logic             flush;
  logic             idle_clr;
  logic             idle_expired_c;

  // State register: lane counter, accumulator and output word.
  always_ff @(posedge i_rd_clk) begin
    if (!i_rd_rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      be_q    <= be_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: pop decision, lane write, transfer and flush.
  always_comb begin
    acc_state = ACC_PARTIAL;
    rd_en_c   = 1'b0;
    out_free  = 1'b0;
    load_full = 1'b0;
    flush     = 1'b0;
    idle_clr  = 1'b0;
    acc_wr    = acc_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    word_d    = word_q;
    be_d      = be_q;
    valid_d   = valid_q;

    if (cnt_q == '0) begin
      acc_state = ACC_EMPTY;
    end else if (cnt_q == CNTW'(PACK)) begin
      acc_state = ACC_FULL;
    end

    rd_en_c  = i_rd_rst_n & ~bus.i_empty & (acc_state != ACC_FULL);
    out_free = ~valid_q | bus.i_ready;

    // Lane decode: the popped entry lands in lane cnt.
    for (int unsigned k = 0; k < PACK; k++) begin
      if (rd_en_c && (cnt_q == CNTW'(k))) begin
        acc_wr[k*DATASIZE +: DATASIZE] = bus.i_rd_data;
      end
    end

    // Complete word: either the completing pop this edge or a stalled full one.
    load_full = out_free &
                ((rd_en_c & (cnt_q == CNTW'(PACK - 1))) | (acc_state == ACC_FULL));
    // A pop in the expiring cycle takes priority over the flush.
    flush     = FLUSH_EN & idle_expired_c & (acc_state == ACC_PARTIAL) &
                ~rd_en_c & out_free;

    acc_d = acc_wr;
    cnt_d = cnt_q + CNTW'(rd_en_c);

    if (out_free) begin
      valid_d = 1'b0;
    end

    if (load_full) begin
      word_d  = acc_wr;
      be_d    = '1;
      valid_d = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (flush) begin
      // Unfilled lanes are already zero since the accumulator clears on unload.
      word_d  = acc_q;
      for (int unsigned k = 0; k < PACK; k++) begin
        be_d[k] = (CNTW'(k) < cnt_q);
      end
      valid_d = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
    end

    idle_clr = rd_en_c | load_full | flush | (acc_state == ACC_EMPTY);
  end

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) u_idle_timer (
    .clk       (i_rd_clk),
    .rst_n     (i_rd_rst_n),
    .clr       (idle_clr),
    .en        (FLUSH_EN),
    .expired_c (idle_expired_c)
  );

  assign bus.o_rd_en   = rd_en_c;
  assign bus.o_word    = word_q;
  assign bus.o_byte_en = be_q;
  assign bus.o_valid   = valid_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running in the read clock domain. It pops DATASIZE-bit entries whenever the FIFO reports not-empty and packs PACK consecutive entries into one wide word. It presents each word on a registered valid/ready stream. If the FIFO stays idle too long, it flushes a partially filled word with per-lane byte enables, so trailing data never sits in the packer indefinitely.

## Interface
Parameters:
- DATASIZE, 8, width of one FIFO entry; must match the FIFO DATASIZE
- PACK, 4, entries per output word (≥2)
- TIMEOUT, 15, idle read clocks before a partial word is flushed; 0 disables flushing
- CNTW, 3, width of the lane counter; must hold PACK (clog2(PACK+1))
- TOW, 4, width of the idle counter; must hold TIMEOUT

Ports:
- i_rd_clk  in  1  read-domain clock, same net that clocks the FIFO read side
- i_rd_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_empty  in  1  FIFO empty flag
- i_rd_data  in  DATASIZE  FIFO read data; valid combinationally for the current read address while i_empty=0
- o_rd_en  out  1  FIFO pop strobe
- o_word  out  DATASIZE*PACK  packed word; lane k = bits [k*DATASIZE +: DATASIZE]
- o_byte_en  out  PACK  lane-valid mask for o_word
- o_valid  out  1  o_word/o_byte_en hold a word
- i_ready  in  1  downstream accepts the word

## Operation
- Pop rule: o_rd_en = i_rd_rst_n & ~i_empty & (cnt < PACK). It never depends on i_ready.
- Pop (o_rd_en=1 at an edge): i_rd_data is written into accumulator lane cnt, and cnt increments. The first entry goes in lane 0 (little-endian packing).
- Output register is free when o_valid=0 or (o_valid & i_ready).
- Transfer triggers:
  - the edge that pops the completing entry (cnt=PACK-1) while the output register is free;
  - otherwise, the first edge with cnt=PACK and the output register free.
  - Either trigger loads o_word, sets o_byte_en to all ones and o_valid to 1, and sets cnt to 0.
- A full accumulator (cnt=PACK) with the output register occupied stalls: o_rd_en is 0 until the transfer happens.
- Idle counter idle:
  - cleared on any pop, on any transfer, and while cnt=0;
  - otherwise increments each edge, saturating at TIMEOUT.
- Flush: when TIMEOUT≠0, idle=TIMEOUT, 0<cnt<PACK, no pop in that cycle, and the output register is free:
  - load o_word with the filled lanes and zeros in the unfilled lanes;
  - set o_byte_en = (1<<cnt)-1 and o_valid=1;
  - clear cnt and idle.
- A pop in the same cycle as an expiring timeout wins: the pop is taken, idle clears, and no flush occurs.
- Output handshake: o_valid stays high and o_word/o_byte_en stay stable until the edge where i_ready=1. At that edge they either reload (back-to-back transfer) or o_valid drops to 0.
- Accumulator state, derived from cnt: EMPTY (cnt=0), PARTIAL (0<cnt<PACK), FULL (cnt=PACK).
  - EMPTY→PARTIAL on a pop.
  - PARTIAL→FULL when the completing entry is popped and the output register is not free.
  - PARTIAL→EMPTY on a direct transfer or a flush.
  - FULL→EMPTY on transfer.

## Timing
- Reset values, all synchronous at the first edge with i_rd_rst_n=0: o_valid=0, o_word=0, o_byte_en=0, cnt=0, idle=0, accumulator=0.
- o_rd_en is forced 0 combinationally while reset is low.
- Reset asserted mid-word or mid-handshake discards the partial word and the held output word. The FIFO is not re-read.
- Latency: o_valid rises on the same edge that pops the completing entry, provided the output register is free.
- Sustained throughput: one word every PACK clocks when the FIFO stays non-empty and i_ready=1.
- Flush latency: TIMEOUT+1 clocks after the last pop.
- All outputs except o_rd_en are registered. o_rd_en is combinational from i_empty and cnt only.

## Structure
- Shared package/header fifo_pkg holds:
  - the default DATASIZE, which is shared with the FIFO;
  - the clog2 helper used for CNTW and TOW.
- Sub-module fifo_rd_idle_timer: saturating idle counter with clear/enable inputs and an expired output.
- The accumulator, lane write decode and output register stay in fifo_rd_packer.

## Test plan
- Stream 8 entries 0x11..0x88, i_empty=0 throughout, i_ready=1 → two words, 0x44332211 then 0x88776655, o_byte_en=4'hF, 4 clocks apart.
- 3 entries 0xA1,0xA2,0xA3, then empty, TIMEOUT=15 → o_word=0x00A3A2A1 and o_byte_en=4'h7 exactly 16 clocks after the last pop.
- i_ready=0 with 8 entries available → the first word is held stable, the accumulator fills, and o_rd_en drops after 8 pops. Raising i_ready yields the second word on the next edge, then o_rd_en resumes.
- A new entry appears on the same cycle the timeout expires → no flush, and the entry lands in lane cnt.
- Reset asserted with o_valid=1 and cnt=2 → next edge o_valid=0, o_byte_en=0, cnt=0, o_rd_en=0 during reset.
- TIMEOUT=0 with 1 entry then idle for 100 clocks → o_valid stays 0.
